// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared FP pipeline definitions: scoreboard geometry, op latencies and the
// slot record tracked for every in-flight FP instruction.
package fpu_pkg;

   localparam int DEPTH = 4;  // stages to writeback, also the longest latency
   localparam int REG_W = 5;  // FP register index width
   localparam int LAT_W = 3;  // latency field width on the decode side
   localparam int REM_W = 3;  // remaining-latency field width in a slot

   localparam logic [LAT_W-1:0] LAT_CVIF = 3'd2;
   localparam logic [LAT_W-1:0] LAT_LOAD = 3'd3;
   localparam logic [LAT_W-1:0] LAT_ADSB = 3'd3;
   localparam logic [LAT_W-1:0] LAT_MULT = 3'd4;

   localparam logic [REM_W-1:0] REM_ZERO = 3'd0;
   localparam logic [REM_W-1:0] REM_ONE  = 3'd1;

   typedef struct packed {
      logic             valid;
      logic             wr;
      logic [REG_W-1:0] rd;
      logic [REM_W-1:0] rem;
   } slot_t;

   // Slot 1 is the youngest entry, slot DEPTH is the writeback stage.
   typedef slot_t [DEPTH:1] sb_t;

   localparam slot_t SLOT_BUBBLE = '{valid: 1'b0, wr: 1'b0,
                                     rd: {REG_W{1'b0}}, rem: {REM_W{1'b0}}};

   // Latency 0 behaves as 1 and anything beyond DEPTH is clamped; the slot
   // stores latency-1 because it is loaded one edge after issue.
   function automatic logic [REM_W-1:0] lat_to_rem(input logic [LAT_W-1:0] lat);
      logic [REM_W-1:0] rem_s;
      if (lat == 3'd0) begin
         rem_s = REM_ZERO;
      end else if (lat > LAT_W'(DEPTH)) begin
         rem_s = REM_W'(DEPTH - 1);
      end else begin
         rem_s = lat - 3'd1;
      end
      return rem_s;
   endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Decoder-to-issue-controller bundle: decoded instruction, flush, issue/stall
// handshake, writeback port and performance counter.
interface fpu_issue_ctrl_if #(
   parameter int CNT_W = 32
);
   import fpu_pkg::*;

   logic             in_valid;
   logic [REG_W-1:0] in_rd;
   logic [REG_W-1:0] in_rs1;
   logic [REG_W-1:0] in_rs2;
   logic             in_use_rs1;
   logic             in_use_rs2;
   logic             in_reg_write;
   logic [LAT_W-1:0] in_lat;
   logic             flush;
   logic             issue;
   logic             stall;
   logic             wb_en;
   logic [REG_W-1:0] wb_rd;
   logic             busy;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output in_valid, in_rd, in_rs1, in_rs2, in_use_rs1, in_use_rs2,
             in_reg_write, in_lat, flush,
      input  issue, stall, wb_en, wb_rd, busy, stall_cnt
   );

   modport slave (
      input  in_valid, in_rd, in_rs1, in_rs2, in_use_rs1, in_use_rs2,
             in_reg_write, in_lat, flush,
      output issue, stall, wb_en, wb_rd, busy, stall_cnt
   );

endinterface

// File: rtl/fpu_sb_match.sv
// Youngest-producer finder for one source operand. The forwarding network
// always picks the youngest writer of a register, so only that slot decides
// whether the operand is ready.
module fpu_sb_match
   import fpu_pkg::*;
(
   input  sb_t              sb,
   input  logic [REG_W-1:0] rs,
   input  logic             use_rs,
   output logic             hazard
);

   logic hit_s;

   // Walk from oldest to youngest so the youngest match overwrites the result.
   always_comb begin
      hit_s = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (sb[k].valid && sb[k].wr && (sb[k].rd == rs)) begin
            hit_s = (sb[k].rem != REM_ZERO);
         end else begin
            hit_s = hit_s;
         end
      end
   end

   assign hazard = use_rs & hit_s;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP issue and hazard controller: a shifting scoreboard of in-flight
// instructions, RAW stall generation, fixed-stage writeback and a saturating
// stall-cycle counter.
module fpu_issue_ctrl
   import fpu_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input logic             clk,
   input logic             rst,
   fpu_issue_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   sb_t              sb_r;
   sb_t              sb_nxt_s;
   logic             haz_rs1_s;
   logic             haz_rs2_s;
   logic             stall_s;
   logic             issue_s;
   logic             busy_s;
   logic [CNT_W-1:0] cnt_r;

   fpu_sb_match u_match_rs1 (
      .sb     (sb_r),
      .rs     (bus.in_rs1),
      .use_rs (bus.in_use_rs1),
      .hazard (haz_rs1_s)
   );

   fpu_sb_match u_match_rs2 (
      .sb     (sb_r),
      .rs     (bus.in_rs2),
      .use_rs (bus.in_use_rs2),
      .hazard (haz_rs2_s)
   );

   // A stall only blocks the presented instruction; flush additionally kills it.
   assign stall_s = bus.in_valid & (haz_rs1_s | haz_rs2_s);
   assign issue_s = bus.in_valid & ~stall_s & ~bus.flush;

   // Next scoreboard image: new entry or bubble in slot 1, everything else
   // moves one stage older with its remaining latency counting down to zero.
   always_comb begin
      sb_nxt_s = sb_r;
      if (issue_s) begin
         sb_nxt_s[1] = '{valid: 1'b1, wr: bus.in_reg_write, rd: bus.in_rd,
                         rem: lat_to_rem(bus.in_lat)};
      end else begin
         sb_nxt_s[1] = SLOT_BUBBLE;
      end
      for (int k = 2; k <= DEPTH; k++) begin
         sb_nxt_s[k] = sb_r[k-1];
         if (sb_r[k-1].rem != REM_ZERO) begin
            sb_nxt_s[k].rem = sb_r[k-1].rem - REM_ONE;
         end else begin
            sb_nxt_s[k].rem = REM_ZERO;
         end
      end
   end

   // Scoreboard register; flush empties every slot in one edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb_r <= {DEPTH{SLOT_BUBBLE}};
      end else if (bus.flush) begin
         sb_r <= {DEPTH{SLOT_BUBBLE}};
      end else begin
         sb_r <= sb_nxt_s;
      end
   end

   // Count cycles lost to RAW hazards, sticking at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (stall_s && !bus.flush && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + CNT_ONE;
      end
   end

   // Any live slot means the pipeline still has work in flight.
   always_comb begin
      busy_s = 1'b0;
      for (int k = 1; k <= DEPTH; k++) begin
         if (sb_r[k].valid) begin
            busy_s = 1'b1;
         end else begin
            busy_s = busy_s;
         end
      end
   end

   assign bus.stall     = stall_s;
   assign bus.issue     = issue_s;
   assign bus.busy      = busy_s;
   assign bus.stall_cnt = cnt_r;
   // The writeback stage is itself a register, so these are flop outputs.
   assign bus.wb_en     = sb_r[DEPTH].valid & sb_r[DEPTH].wr;
   assign bus.wb_rd     = sb_r[DEPTH].rd;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl. The reference model keeps a list
// of issued instructions with their issue cycle and reasons about age.
module tb_fpu_issue_ctrl;

   localparam int D = 4;

   typedef struct {
      logic       v;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       wr;
      logic [2:0] lat;
      logic       fl;
   } stim_t;

   typedef struct {
      int         t;
      int         lat;
      logic       wr;
      logic [4:0] rd;
   } inst_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   inst_t      q[$];
   int         m_cnt = 0;
   logic       exp_issue, exp_stall, exp_wb_en, exp_busy;
   logic [4:0] exp_wb_rd;

   fpu_issue_ctrl_if #(.CNT_W(4)) bus ();

   fpu_issue_ctrl #(.CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic stim_t mk(input logic v, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic wr,
                                input logic [2:0] lat, input logic fl);
      stim_t s;
      s.v = v; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2;
      s.wr = wr; s.lat = lat; s.fl = fl;
      return s;
   endfunction

   task automatic idle();
      bus.in_valid = 1'b0; bus.in_rd = 5'd0; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0;
      bus.in_use_rs1 = 1'b0; bus.in_use_rs2 = 1'b0; bus.in_reg_write = 1'b0;
      bus.in_lat = 3'd1; bus.flush = 1'b0;
   endtask

   // Reference: an instruction issued in cycle t is "age" cycle-t old; it is
   // in flight for ages 1..D, forwardable once age reaches its latency, and
   // written back at age D.
   task automatic model_eval(input stim_t s);
      int   ba1, ba2, age;
      logic h1, h2;
      ba1 = 99; ba2 = 99; h1 = 1'b0; h2 = 1'b0;
      exp_busy = 1'b0; exp_wb_en = 1'b0; exp_wb_rd = 5'd0;
      foreach (q[i]) begin
         age = cyc - q[i].t;
         if (age >= 1 && age <= D) begin
            exp_busy = 1'b1;
            if (q[i].wr) begin
               if (age == D) begin exp_wb_en = 1'b1; exp_wb_rd = q[i].rd; end
               if (q[i].rd == s.rs1 && age < ba1) begin ba1 = age; h1 = (age < q[i].lat); end
               if (q[i].rd == s.rs2 && age < ba2) begin ba2 = age; h2 = (age < q[i].lat); end
            end
         end
      end
      exp_stall = s.v && ((s.u1 && h1) || (s.u2 && h2));
      exp_issue = s.v && !exp_stall && !s.fl;
   endtask

   task automatic apply(input stim_t s);
      @(negedge clk);
      bus.in_valid = s.v; bus.in_rd = s.rd; bus.in_rs1 = s.rs1; bus.in_rs2 = s.rs2;
      bus.in_use_rs1 = s.u1; bus.in_use_rs2 = s.u2; bus.in_reg_write = s.wr;
      bus.in_lat = s.lat; bus.flush = s.fl;
      #1;
      model_eval(s);
   endtask

   task automatic advance(input stim_t s);
      int l;
      l = (s.lat == 3'd0) ? 1 : ((int'(s.lat) > D) ? D : int'(s.lat));
      if (exp_issue) q.push_back('{cyc, l, s.wr, s.rd});
      if (s.fl) q.delete();
      if (exp_stall && !s.fl && m_cnt < 15) m_cnt++;
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst = 1'b1;
      q.delete();
      m_cnt = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      idle();
      rst = 1'b1;
      bus.in_valid = 1'b1; bus.in_rs1 = 5'd3; bus.in_use_rs1 = 1'b1;
      #1;
      n_vec++; if (bus.wb_en !== 1'b0) begin n_err++; $display("FAIL reset_wb_en got %b want 0", bus.wb_en); end
      n_vec++; if (bus.wb_rd !== 5'd0) begin n_err++; $display("FAIL reset_wb_rd got %0d want 0", bus.wb_rd); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      n_vec++; if (bus.stall_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", bus.stall_cnt); end
      n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", bus.stall); end
      n_vec++; if (bus.issue !== 1'b1) begin n_err++; $display("FAIL reset_issue got %b want 1", bus.issue); end
      idle();
      q.delete();
      m_cnt = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_mult_raw();
      stim_t s[$];
      int nst;
      do_reset();
      nst = 0;
      s.push_back(mk(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0));
      for (int i = 0; i < 4; i++) s.push_back(mk(1'b1, 5'd10, 5'd3, 5'd1, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0));
      foreach (s[i]) begin
         apply(s[i]);
         n_vec++; if (bus.issue !== exp_issue) begin n_err++; $display("FAIL mult_issue i=%0d got %b want %b", i, bus.issue, exp_issue); end
         n_vec++; if (bus.stall !== exp_stall) begin n_err++; $display("FAIL mult_stall i=%0d got %b want %b", i, bus.stall, exp_stall); end
         n_vec++; if (bus.wb_en !== exp_wb_en) begin n_err++; $display("FAIL mult_wb_en i=%0d got %b want %b", i, bus.wb_en, exp_wb_en); end
         if (exp_wb_en) begin n_vec++; if (bus.wb_rd !== exp_wb_rd) begin n_err++; $display("FAIL mult_wb_rd i=%0d got %0d want %0d", i, bus.wb_rd, exp_wb_rd); end end
         n_vec++; if (bus.stall_cnt !== 4'(m_cnt)) begin n_err++; $display("FAIL mult_cnt i=%0d got %0d want %0d", i, bus.stall_cnt, m_cnt); end
         if (bus.stall === 1'b1) nst++;
         advance(s[i]);
      end
      n_vec++; if (nst !== 3) begin n_err++; $display("FAIL mult_nstall got %0d want 3", nst); end
      n_vec++; if (bus.stall_cnt !== 4'd3) begin n_err++; $display("FAIL mult_final_cnt got %0d want 3", bus.stall_cnt); end
   endtask

   task automatic test_load_rs2();
      stim_t s[$];
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         s.delete();
         s.push_back(mk(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0));
         for (int i = 0; i < 3; i++) s.push_back(mk(1'b1, 5'd6, 5'd2, 5'd5, 1'b0, (pass == 0), 1'b1, 3'd2, 1'b0));
         foreach (s[i]) begin
            apply(s[i]);
            n_vec++; if (bus.issue !== exp_issue) begin n_err++; $display("FAIL load_issue p=%0d i=%0d got %b want %b", pass, i, bus.issue, exp_issue); end
            n_vec++; if (bus.stall !== exp_stall) begin n_err++; $display("FAIL load_stall p=%0d i=%0d got %b want %b", pass, i, bus.stall, exp_stall); end
            n_vec++; if (bus.busy !== exp_busy) begin n_err++; $display("FAIL load_busy p=%0d i=%0d got %b want %b", pass, i, bus.busy, exp_busy); end
            advance(s[i]);
         end
         n_vec++; if (bus.stall_cnt !== ((pass == 0) ? 4'd2 : 4'd0)) begin n_err++; $display("FAIL load_cnt p=%0d got %0d", pass, bus.stall_cnt); end
      end
   endtask

   task automatic test_back_to_back();
      stim_t s[$];
      logic [4:0] seen[$];
      do_reset();
      for (int i = 1; i <= 4; i++) s.push_back(mk(1'b1, 5'(i), 5'(i + 8), 5'(i + 12), 1'b1, 1'b1, 1'b1, 3'd4, 1'b0));
      for (int i = 0; i < 5; i++) s.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0));
      foreach (s[i]) begin
         apply(s[i]);
         n_vec++; if (bus.issue !== exp_issue) begin n_err++; $display("FAIL b2b_issue i=%0d got %b want %b", i, bus.issue, exp_issue); end
         n_vec++; if (bus.wb_en !== exp_wb_en) begin n_err++; $display("FAIL b2b_wb_en i=%0d got %b want %b", i, bus.wb_en, exp_wb_en); end
         if (exp_wb_en) begin n_vec++; if (bus.wb_rd !== exp_wb_rd) begin n_err++; $display("FAIL b2b_wb_rd i=%0d got %0d want %0d", i, bus.wb_rd, exp_wb_rd); end end
         if (bus.wb_en === 1'b1) seen.push_back(bus.wb_rd);
         advance(s[i]);
      end
      n_vec++; if (seen.size() !== 4) begin n_err++; $display("FAIL b2b_wb_count got %0d want 4", seen.size()); end
      else foreach (seen[i]) begin n_vec++; if (seen[i] !== 5'(i + 1)) begin n_err++; $display("FAIL b2b_wb_order k=%0d got %0d want %0d", i, seen[i], i + 1); end end
   endtask

   task automatic test_youngest();
      stim_t s[$];
      do_reset();
      s.push_back(mk(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0));
      s.push_back(mk(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0));
      s.push_back(mk(1'b1, 5'd8, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0));
      foreach (s[i]) begin
         apply(s[i]);
         n_vec++; if (bus.stall !== exp_stall) begin n_err++; $display("FAIL young_stall i=%0d got %b want %b", i, bus.stall, exp_stall); end
         n_vec++; if (bus.issue !== 1'b1) begin n_err++; $display("FAIL young_issue i=%0d got %b want 1", i, bus.issue); end
         advance(s[i]);
      end
   endtask

   task automatic test_flush();
      stim_t s[$];
      do_reset();
      s.push_back(mk(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0));
      s.push_back(mk(1'b1, 5'd4, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0));
      s.push_back(mk(1'b1, 5'd4, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1));
      s.push_back(mk(1'b1, 5'd4, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0));
      foreach (s[i]) begin
         apply(s[i]);
         n_vec++; if (bus.issue !== exp_issue) begin n_err++; $display("FAIL flush_issue i=%0d got %b want %b", i, bus.issue, exp_issue); end
         n_vec++; if (bus.stall !== exp_stall) begin n_err++; $display("FAIL flush_stall i=%0d got %b want %b", i, bus.stall, exp_stall); end
         n_vec++; if (bus.busy !== exp_busy) begin n_err++; $display("FAIL flush_busy i=%0d got %b want %b", i, bus.busy, exp_busy); end
         n_vec++; if (bus.wb_en !== exp_wb_en) begin n_err++; $display("FAIL flush_wb_en i=%0d got %b want %b", i, bus.wb_en, exp_wb_en); end
         n_vec++; if (bus.stall_cnt !== 4'(m_cnt)) begin n_err++; $display("FAIL flush_cnt i=%0d got %0d want %0d", i, bus.stall_cnt, m_cnt); end
         advance(s[i]);
      end
      n_vec++; if (bus.stall_cnt !== 4'd1) begin n_err++; $display("FAIL flush_final_cnt got %0d want 1", bus.stall_cnt); end
   endtask

   task automatic test_sat_and_reset();
      stim_t s;
      do_reset();
      s = mk(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0);
      for (int i = 0; i < 28; i++) begin
         apply(s);
         n_vec++; if (bus.stall !== exp_stall) begin n_err++; $display("FAIL sat_stall i=%0d got %b want %b", i, bus.stall, exp_stall); end
         n_vec++; if (bus.stall_cnt !== 4'(m_cnt)) begin n_err++; $display("FAIL sat_cnt i=%0d got %0d want %0d", i, bus.stall_cnt, m_cnt); end
         advance(s);
      end
      n_vec++; if (bus.stall_cnt !== 4'hF) begin n_err++; $display("FAIL sat_final got %0d want 15", bus.stall_cnt); end
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL sat_busy_pre got %b want 1", bus.busy); end
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_rs1 = 5'd9; bus.in_use_rs1 = 1'b1;
      rst = 1'b1;
      #1;
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
      n_vec++; if (bus.wb_en !== 1'b0) begin n_err++; $display("FAIL midrst_wb_en got %b want 0", bus.wb_en); end
      n_vec++; if (bus.wb_rd !== 5'd0) begin n_err++; $display("FAIL midrst_wb_rd got %0d want 0", bus.wb_rd); end
      n_vec++; if (bus.stall_cnt !== 4'd0) begin n_err++; $display("FAIL midrst_cnt got %0d want 0", bus.stall_cnt); end
      n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL midrst_stall got %b want 0", bus.stall); end
      idle();
      q.delete();
      m_cnt = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_random();
      stim_t s;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         s = mk(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));
         apply(s);
         n_vec++; if (bus.issue !== exp_issue) begin n_err++; $display("FAIL rnd_issue i=%0d got %b want %b", i, bus.issue, exp_issue); end
         n_vec++; if (bus.stall !== exp_stall) begin n_err++; $display("FAIL rnd_stall i=%0d got %b want %b", i, bus.stall, exp_stall); end
         n_vec++; if (bus.wb_en !== exp_wb_en) begin n_err++; $display("FAIL rnd_wb_en i=%0d got %b want %b", i, bus.wb_en, exp_wb_en); end
         if (exp_wb_en) begin n_vec++; if (bus.wb_rd !== exp_wb_rd) begin n_err++; $display("FAIL rnd_wb_rd i=%0d got %0d want %0d", i, bus.wb_rd, exp_wb_rd); end end
         n_vec++; if (bus.busy !== exp_busy) begin n_err++; $display("FAIL rnd_busy i=%0d got %b want %b", i, bus.busy, exp_busy); end
         n_vec++; if (bus.stall_cnt !== 4'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt i=%0d got %0d want %0d", i, bus.stall_cnt, m_cnt); end
         advance(s);
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_mult_raw();
      test_load_rs2();
      test_back_to_back();
      test_youngest();
      test_flush();
      test_sat_and_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Issue and hazard controller for the floating-point pipeline. It sits between the FP decoder and the FPU datapath and tracks every in-flight FP instruction in a fixed-depth scoreboard that records destination register and remaining latency. It stalls a dependent instruction until its source can be forwarded, and drives the register-file write enable and index at the writeback stage. It also counts stall cycles for performance monitoring.

## Interface
- DEPTH, 4: pipeline stages to writeback; also the maximum latency.
- REG_W, 5: FP register index width.
- CNT_W, 32: stall counter width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decoded FP instruction presented this cycle.
- in_rd  in  REG_W  destination register.
- in_rs1, in_rs2  in  REG_W  source registers.
- in_use_rs1, in_use_rs2  in  1  source actually read.
- in_reg_write  in  1  instruction writes the FP register file.
- in_lat  in  3  cycles until the result is forwardable. Valid range 1..DEPTH; 0 is treated as 1; values above DEPTH are clamped to DEPTH.
- flush  in  1  kill all in-flight entries.
- issue  out  1  instruction accepted this cycle (combinational).
- stall  out  1  RAW hazard on a presented instruction (combinational).
- wb_en  out  REG_W-independent 1  register-file write enable (registered).
- wb_rd  out  REG_W  register-file write index (registered).
- busy  out  1  any valid scoreboard entry.
- stall_cnt  out  CNT_W  saturating stall-cycle count.

## Operation
- Scoreboard slots s[1..DEPTH]. Each slot holds {valid, wr, rd, rem}.
- Every edge shifts s[k] to s[k+1]. rem decrements and saturates at 0. s[DEPTH] falls off.
- On issue, s[1] loads {1, in_reg_write, in_rd, lat-1}. Otherwise s[1] loads a bubble (valid=0). A stall never freezes the pipeline.
- Hazard per source when in_use_rsX=1:
  - Find the youngest slot (lowest k) with valid & wr & rd==rsX.
  - A hazard exists if that slot's rem != 0.
  - Older matching slots are ignored, because the forwarding network selects the youngest producer.
- stall = in_valid & (hazard_rs1 | hazard_rs2).
- issue = in_valid & ~stall & ~flush.
- wb_en = s[DEPTH].valid & s[DEPTH].wr; wb_rd = s[DEPTH].rd. Writeback is always at a fixed stage, so there is no write-port conflict and no WAW reordering.
- flush: all valid bits clear at the next edge. Any instruction presented in the same cycle is not issued. wb_en is 0 from the next cycle.
- stall_cnt increments on cycles where in_valid & stall & ~flush, and holds at all-ones.
- busy = OR of all valid bits.

## Timing
- Reset (asynchronous): all valid=0, wb_en=0, wb_rd=0, stall_cnt=0. issue and stall then follow their combinational equations with an empty scoreboard.
- An instruction issued in cycle t with latency L:
  - It sits in s[k] during cycle t+k with rem=L-k.
  - A consumer presented in cycle t+k stalls while k<L and issues in cycle t+L.
  - wb_en is asserted in cycle t+DEPTH.
- Back-to-back independent issue is sustained at 1 per cycle.
- Reset asserted mid-operation drops all entries immediately. No writeback occurs for them.
- in_reg_write=0 entries occupy slots but never cause a hazard or writeback.

## Structure
- Shared package fpu_pkg holds:
  - DEPTH and REG_W.
  - Latency constants: LAT_CVIF=2, LAT_LOAD=3, LAT_ADSB=3, LAT_MULT=4.
  - The slot struct {valid, wr, rd, rem}.
- Sub-module fpu_sb_match: combinational youngest-match priority finder. It takes the slot array and a source register and returns hazard. It is instantiated twice, once per source.
- The top level holds the slot registers, writeback outputs and stall counter.

## Test plan
- Multiply latency 4, rd=3, at t; add with rs1=3 presented from t+1 → stall is high for t+1..t+3, issue at t+4, stall_cnt=3, wb_en and wb_rd=3 at t+4.
- Load latency 3, rd=5, at t; consumer with rs2=5 and in_use_rs2=1 at t+1 → 2 stall cycles. The same consumer with in_use_rs2=0 → issues at t+1 with no stall.
- Four independent ops with rd=1..4 on consecutive cycles → no stall; wb_rd=1,2,3,4 on cycles t+4..t+7 with wb_en continuously high.
- Op A latency 4, rd=7, at t; op B latency 1, rd=7, at t+1; consumer rs1=7 at t+2 → no stall (youngest match wins).
- Stall in progress, then flush for one cycle → the presented instruction is not issued that cycle; busy=0 and wb_en=0 afterwards; the consumer issues the following cycle.
- With CNT_W=4, hold a hazard for 20 cycles by repeatedly re-issuing a latency-4 producer → stall_cnt saturates at 15. Asserting rst mid-run → all outputs return to their reset values immediately.
